alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencer stage directly upstream of the team's 32-bit combinational ALU.
- Accepts one command at a time over a valid/ready handshake and reads two operands from an internal 8x32 register file.
- Drives the ALU's operand1/operand2/aluop inputs, captures its result and flags, and writes the result back to the register file.
- Produces a one-cycle response pulse carrying the result and flags, and keeps a sticky overflow status bit.

Parameters:
- NREGS, 8, number of register-file entries; must be a power of two, minimum 2.
- AW, 3, register address width; equals log2(NREGS).
- DW, 32, datapath width; must match the ALU operand width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  4  opcode: 0..7 = ALU aluop (COMPLEMENT, AND, XOR, OR, DECREMENT, ADD, SUB, INCREMENT); 8 = LOADI; 9..15 = reserved
- cmd_rd  input  AW  destination register
- cmd_rs1  input  AW  source 1, drives operand1
- cmd_rs2  input  AW  source 2, drives operand2
- cmd_imm  input  DW  immediate; used only by LOADI
- alu_operand1  output  DW  to ALU operand1
- alu_operand2  output  DW  to ALU operand2
- alu_aluop  output  4  to ALU aluop
- alu_result  input  DW  from ALU alu_out
- alu_overflow  input  1  from ALU add_sub_overflow
- alu_zero  input  1  from ALU zero
- rsp_valid  output  1  one-cycle completion pulse
- rsp_data  output  DW  result written to rd
- rsp_zero  output  1  result == 0
- rsp_overflow  output  1  ADD/SUB signed overflow
- ovf_sticky  output  1  set by any overflowing response
- ovf_clr  input  1  clears ovf_sticky
- dbg_addr  input  AW  debug read address
- dbg_data  output  DW  combinational read of rf[dbg_addr]; r0 reads 0

Behaviour:
- States: IDLE, EXEC, WB.
- cmd_ready = (state == IDLE). Handshake occurs when cmd_valid && cmd_ready.
- IDLE on handshake:
  - latch op into op_q, rd into rd_q, imm into imm_q;
  - latch op1_q = rf[rs1] and op2_q = rf[rs2], with r0 reading 0;
  - go to EXEC.
- EXEC (1 cycle):
  - alu_operand1 = op1_q, alu_operand2 = op2_q, alu_aluop = op_q, all driven from registers.
  - End of cycle, ALU opcodes (0..7): res_q = alu_result, zero_q = alu_zero, ovf_q = alu_overflow.
  - LOADI: res_q = imm_q, zero_q = (imm_q == 0), ovf_q = 0; ALU outputs ignored.
  - Reserved opcodes (9..15): res_q = 0, zero_q = 1, ovf_q = 0.
  - Go to WB.
- WB (1 cycle):
  - rsp_valid = 1 with rsp_data/rsp_zero/rsp_overflow = res_q/zero_q/ovf_q.
  - rf[rd_q] <= res_q unless rd_q == 0 (r0 is hardwired 0; writes dropped).
  - Go to IDLE.
- Latency: handshake at cycle N gives rsp_valid at cycle N+2. Throughput is one command per 3 cycles; next handshake earliest at N+3.
- No response backpressure: rsp_valid is a single-cycle pulse, and rsp_* hold their last value outside the pulse.
- Operand reads use register-file contents as of the handshake edge. A WB write in the same cycle cannot occur because cmd_ready is low in WB.
- ovf_sticky:
  - set on a WB cycle with ovf_q = 1; cleared by ovf_clr;
  - if both happen in the same cycle, set wins.
- alu_operand1/2 and alu_aluop hold their registered values in all states; they are only meaningful in EXEC.
- Reset values (also apply to reset mid-operation):
  - state = IDLE, so cmd_ready = 1 in the cycle after reset;
  - all rf entries = 0;
  - op1_q, op2_q, res_q, imm_q, op_q, rd_q = 0;
  - rsp_valid, rsp_zero, rsp_overflow, ovf_sticky = 0;
  - alu_aluop = 0.
- Reset during EXEC or WB aborts the command: no writeback and no rsp_valid.

Decomposition:
- Shared package alu_pkg: the 4-bit opcode constants (COMPLEMENT..INCREMENT = 0..7, LOADI = 8) and the FSM state encoding.
- The ALU source should migrate its local opcode constants to alu_pkg.
- One natural sub-module: alu_regfile, an NREGS x DW array with two combinational read ports plus one debug read port, one synchronous write port, r0 forced to 0, and synchronous reset clear.

Test Plan:
- LOADI r1, 0x7FFFFFFF; LOADI r2, 1; ADD r3 = r1 + r2 -> rsp_data = 0x80000000, rsp_overflow = 1, ovf_sticky = 1; dbg_addr = 3 reads 0x80000000.
- LOADI r4, 5; SUB r5 = r4 - r4 -> rsp_data = 0, rsp_zero = 1, rsp_overflow = 0.
- LOADI r0, 0x1234 -> rsp_data = 0x1234, but dbg_addr = 0 reads 0; ADD r6 = r0 + r4 -> 5.
- cmd_valid held high with 3 queued commands -> handshakes at cycles N, N+3, N+6; each rsp_valid exactly 2 cycles after its handshake; cmd_ready low in EXEC and WB.
- rst asserted in the EXEC cycle of INCREMENT r7 = r4 + 1 -> no rsp_valid; r7 = 0 and all rf = 0 afterwards; cmd_ready = 1 the cycle after rst deasserts.
- ovf_clr asserted in the same cycle as an overflowing WB -> ovf_sticky = 1; ovf_clr alone on the next cycle -> ovf_sticky = 0. Reserved opcode 12 -> rsp_data = 0, rsp_zero = 1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants and sequencer FSM state encoding for
//               the ALU and its upstream command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_NREGS = 8;
    localparam int c_AW    = 3;
    localparam int c_DW    = 32;

    localparam logic [3:0] c_OP_COMPLEMENT = 4'd0;
    localparam logic [3:0] c_OP_AND        = 4'd1;
    localparam logic [3:0] c_OP_XOR        = 4'd2;
    localparam logic [3:0] c_OP_OR         = 4'd3;
    localparam logic [3:0] c_OP_DECREMENT  = 4'd4;
    localparam logic [3:0] c_OP_ADD        = 4'd5;
    localparam logic [3:0] c_OP_SUB        = 4'd6;
    localparam logic [3:0] c_OP_INCREMENT  = 4'd7;
    localparam logic [3:0] c_OP_LOADI      = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl_if
// Description : Command, ALU, response and debug signals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_ctrl_if #(
    parameter int AW = 3,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic [DW-1:0] cmd_imm;

    logic [DW-1:0] alu_operand1;
    logic [DW-1:0] alu_operand2;
    logic [3:0]    alu_aluop;
    logic [DW-1:0] alu_result;
    logic          alu_overflow;
    logic          alu_zero;

    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_zero;
    logic          rsp_overflow;
    logic          ovf_sticky;
    logic          ovf_clr;

    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  alu_result, alu_overflow, alu_zero, ovf_clr, dbg_addr,
        output cmd_ready, alu_operand1, alu_operand2, alu_aluop,
        output rsp_valid, rsp_data, rsp_zero, rsp_overflow, ovf_sticky, dbg_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output alu_result, alu_overflow, alu_zero, ovf_clr, dbg_addr,
        input  cmd_ready, alu_operand1, alu_operand2, alu_aluop,
        input  rsp_valid, rsp_data, rsp_zero, rsp_overflow, ovf_sticky, dbg_data
    );

endinterface : alu_seq_ctrl_if
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : NREGS x DW register file, two operand read ports, one debug
//               read port, one synchronous write port; r0 reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [DW-1:0] i_wdata,
    input  wire logic [AW-1:0] i_raddr1,
    output logic      [DW-1:0] o_rdata1,
    input  wire logic [AW-1:0] i_raddr2,
    output logic      [DW-1:0] o_rdata2,
    input  wire logic [AW-1:0] i_dbg_addr,
    output logic      [DW-1:0] o_dbg_data
);

    logic [DW-1:0] r_mem [NREGS];

    // Writes to r0 are dropped so the entry stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1   = (i_raddr1   == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2   = (i_raddr2   == '0) ? '0 : r_mem[i_raddr2];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule : alu_regfile
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Single-command sequencer feeding a combinational ALU: reads
//               operands, executes, writes back and pulses a response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_seq_ctrl_if.slave  bus
);
    import alu_pkg::*;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_cmd_ready;
    logic          w_rsp_valid;
    logic          w_rf_we;
    logic          w_hs;

    logic [3:0]    r_op;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_op1;
    logic [DW-1:0] r_op2;
    logic [DW-1:0] r_res;
    logic          r_zero;
    logic          r_ovf;
    logic          r_ovf_sticky;

    logic [DW-1:0] w_rs1_data;
    logic [DW-1:0] w_rs2_data;

    alu_regfile #(
        .NREGS (NREGS),
        .AW    (AW),
        .DW    (DW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_rf_we),
        .i_waddr    (r_rd),
        .i_wdata    (r_res),
        .i_raddr1   (bus.cmd_rs1),
        .o_rdata1   (w_rs1_data),
        .i_raddr2   (bus.cmd_rs2),
        .o_rdata2   (w_rs2_data),
        .i_dbg_addr (bus.dbg_addr),
        .o_dbg_data (bus.dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_rf_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
                w_rsp_valid = 1'b1;
                w_rf_we     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_hs = bus.cmd_valid && w_cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= '0;
            r_rd   <= '0;
            r_imm  <= '0;
            r_op1  <= '0;
            r_op2  <= '0;
            r_res  <= '0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_op  <= bus.cmd_op;
                r_rd  <= bus.cmd_rd;
                r_imm <= bus.cmd_imm;
                r_op1 <= w_rs1_data;
                r_op2 <= w_rs2_data;
            end
            // Opcodes 0..7 pass straight through to the ALU; 8 and above are local.
            if (r_state == ST_EXEC) begin
                if (!r_op[3]) begin
                    r_res  <= bus.alu_result;
                    r_zero <= bus.alu_zero;
                    r_ovf  <= bus.alu_overflow;
                end else if (r_op == c_OP_LOADI) begin
                    r_res  <= r_imm;
                    r_zero <= (r_imm == '0);
                    r_ovf  <= 1'b0;
                end else begin
                    r_res  <= '0;
                    r_zero <= 1'b1;
                    r_ovf  <= 1'b0;
                end
            end
        end
    end

    // A new overflow takes priority over a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_rsp_valid && r_ovf) begin
            r_ovf_sticky <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign bus.cmd_ready    = w_cmd_ready;
    assign bus.alu_operand1 = r_op1;
    assign bus.alu_operand2 = r_op2;
    assign bus.alu_aluop    = r_op;
    assign bus.rsp_valid    = w_rsp_valid;
    assign bus.rsp_data     = r_res;
    assign bus.rsp_zero     = r_zero;
    assign bus.rsp_overflow = r_ovf;
    assign bus.ovf_sticky   = r_ovf_sticky;

endmodule : alu_seq_ctrl
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Directed and random command sequences against a behavioural
//               register-file/ALU model, with an attached ALU stand-in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   hs_cyc;
    bit   hold;

    logic [31:0] m_rf [8];
    bit          m_sticky;

    alu_seq_ctrl_if #(.AW(3), .DW(32)) bus ();

    alu_seq_ctrl #(.NREGS(8), .AW(3), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the downstream 32-bit combinational ALU.
    always_comb begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        v;
        a = bus.alu_operand1;
        b = bus.alu_operand2;
        r = '0;
        v = 1'b0;
        case (bus.alu_aluop)
            4'd0: r = ~a;
            4'd1: r = a & b;
            4'd2: r = a ^ b;
            4'd3: r = a | b;
            4'd4: r = a - 32'd1;
            4'd5: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd6: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd7: r = a + 32'd1;
            default: r = 32'hDEAD_BEEF;
        endcase
        bus.alu_result   = r;
        bus.alu_overflow = v;
        bus.alu_zero     = (r == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] imm, output logic [31:0] res,
                                    output bit z, output bit o);
        longint sa;
        longint sb;
        longint s;
        longint lim;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = 64'sh7FFF_FFFF;
        o   = 1'b0;
        case (op)
            4'd0: res = ~a;
            4'd1: res = a & b;
            4'd2: res = a ^ b;
            4'd3: res = a | b;
            4'd4: res = a - 1;
            4'd5: begin res = a + b; s = sa + sb; o = (s > lim) || (s < -lim - 1); end
            4'd6: begin res = a - b; s = sa - sb; o = (s > lim) || (s < -lim - 1); end
            4'd7: res = a + 1;
            4'd8: res = imm;
            default: res = 32'd0;
        endcase
        z = (res == 32'd0);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
        m_sticky = 1'b0;
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic [31:0] imm, input bit clr_wb);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          z;
        bit          o;
        int          n;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_idle", bus.cmd_ready, 1);
        a = m_rf[rs1];
        b = m_rf[rs2];
        ref_cmd(op, a, b, imm, res, z, o);
        @(posedge clk); #1;
        hs_cyc = cyc;
        if (!hold) bus.cmd_valid = 1'b0;
        chk("ready_exec", bus.cmd_ready, 0);
        chk("rsp_valid_exec", bus.rsp_valid, 0);
        chk("alu_operand1", bus.alu_operand1, a);
        chk("alu_operand2", bus.alu_operand2, b);
        chk("alu_aluop", bus.alu_aluop, op);
        @(posedge clk); #1;
        if (clr_wb) bus.ovf_clr = 1'b1;
        chk("ready_wb", bus.cmd_ready, 0);
        chk("rsp_valid_wb", bus.rsp_valid, 1);
        chk("rsp_data", bus.rsp_data, res);
        chk("rsp_zero", bus.rsp_zero, z);
        chk("rsp_overflow", bus.rsp_overflow, o);
        if (rd != 3'd0) m_rf[rd] = res;
        m_sticky = o ? 1'b1 : (clr_wb ? 1'b0 : m_sticky);
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        chk("rsp_valid_after", bus.rsp_valid, 0);
        chk("rsp_data_hold", bus.rsp_data, res);
        chk("ovf_sticky", bus.ovf_sticky, m_sticky);
    endtask

    task automatic dbg_chk(input logic [2:0] addr);
        bus.dbg_addr = addr;
        #1;
        chk($sformatf("dbg_r%0d", addr), bus.dbg_data, m_rf[addr]);
    endtask

    task automatic dbg_all();
        for (int i = 0; i < 8; i++) dbg_chk(3'(i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int h1;
        int h2;
        int h3;
        checks = 0;
        errors = 0;
        cyc    = 0;
        hold   = 1'b0;
        rst    = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_rs1   = '0;
        bus.cmd_rs2   = '0;
        bus.cmd_imm   = '0;
        bus.ovf_clr   = 1'b0;
        bus.dbg_addr  = '0;
        model_clear();

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_ready", bus.cmd_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_data", bus.rsp_data, 0);
        chk("reset_rsp_zero", bus.rsp_zero, 0);
        chk("reset_rsp_ovf", bus.rsp_overflow, 0);
        chk("reset_sticky", bus.ovf_sticky, 0);
        chk("reset_aluop", bus.alu_aluop, 0);
        dbg_all();

        // Signed overflow on ADD and sticky flag
        do_cmd(4'd8, 3'd1, 3'd0, 3'd0, 32'h7FFF_FFFF, 1'b0);
        do_cmd(4'd8, 3'd2, 3'd0, 3'd0, 32'h0000_0001, 1'b0);
        do_cmd(4'd5, 3'd3, 3'd1, 3'd2, 32'h0, 1'b0);
        chk("add_ovf_data", m_rf[3], 32'h8000_0000);
        chk("add_ovf_sticky", bus.ovf_sticky, 1);
        dbg_chk(3'd3);

        do_cmd(4'd8, 3'd4, 3'd0, 3'd0, 32'd5, 1'b0);
        do_cmd(4'd6, 3'd5, 3'd4, 3'd4, 32'h0, 1'b0);

        // r0 is hardwired to zero
        do_cmd(4'd8, 3'd0, 3'd0, 3'd0, 32'h1234, 1'b0);
        dbg_chk(3'd0);
        do_cmd(4'd5, 3'd6, 3'd0, 3'd4, 32'h0, 1'b0);
        dbg_chk(3'd6);

        // Back-to-back commands with cmd_valid held high
        hold = 1'b1;
        do_cmd(4'd1, 3'd1, 3'd1, 3'd4, 32'h0, 1'b0);
        h1 = hs_cyc;
        do_cmd(4'd2, 3'd2, 3'd3, 3'd6, 32'h0, 1'b0);
        h2 = hs_cyc;
        do_cmd(4'd3, 3'd7, 3'd5, 3'd3, 32'h0, 1'b0);
        h3 = hs_cyc;
        hold = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("hs_gap_1", 32'(h2 - h1), 32'd3);
        chk("hs_gap_2", 32'(h3 - h2), 32'd3);

        // Reset in the EXEC cycle aborts the command
        bus.cmd_op    = 4'd7;
        bus.cmd_rd    = 3'd7;
        bus.cmd_rs1   = 3'd4;
        bus.cmd_rs2   = 3'd0;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        chk("abort_in_exec", bus.cmd_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        chk("abort_ready", bus.cmd_ready, 1);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_sticky", bus.ovf_sticky, 0);
        @(posedge clk); #1;
        chk("abort_no_pulse", bus.rsp_valid, 0);
        dbg_all();

        // Overflow set wins over a simultaneous clear
        do_cmd(4'd8, 3'd1, 3'd0, 3'd0, 32'h7FFF_FFFF, 1'b0);
        do_cmd(4'd8, 3'd2, 3'd0, 3'd0, 32'h0000_0001, 1'b0);
        do_cmd(4'd5, 3'd3, 3'd1, 3'd2, 32'h0, 1'b1);
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        m_sticky = 1'b0;
        chk("ovf_clr_alone", bus.ovf_sticky, m_sticky);

        // Reserved opcode
        do_cmd(4'd12, 3'd4, 3'd1, 3'd2, 32'hFFFF_FFFF, 1'b0);
        dbg_chk(3'd4);

        // Random stimulus
        for (int i = 1; i < 8; i++) begin
            do_cmd(4'd8, 3'(i), 3'd0, 3'd0, $urandom, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            do_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   $urandom, 1'($urandom_range(0, 1)));
        end
        dbg_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_seq_ctrl
`default_nettype wire
